ddr3_rd_arbiter: RTL and testbench

Shares the single DDR3 read engine (`ddr3_rd_control`) between NREQ command state machines, for example the fill-readout and buffer-dump machines. Each requester asks for a read with its own start address and burst count. The block grants one requester at a time by round robin, forwards that requester's parameters to the reader, synchronizes the reader's completion flag, and returns a done pulse. The block sits between the command state machines and the DDR3 reader, in the `clk` domain.

---
 rtl/ddr3_pkg.sv | 12 +
 rtl/ddr3_rr_pick.sv | 23 ++
 rtl/ddr3_rd_arbiter.sv | 115 +++++++++++
 tb/tb_ddr3_rd_arbiter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ddr3_pkg.sv
// ddr3_pkg: widths, arbiter states and defaults shared by the DDR3 read arbiter.
package ddr3_pkg;
   localparam int DDR3_ADDR_W         = 23;
   localparam int DDR3_BURST_W        = 24;
   localparam int DDR3_RD_TIMEOUT_DEF = 1 << 20;
   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_READ, ST_WAIT_CLR} arb_state_t;
   function automatic logic [2:0] oh2idx(input logic [7:0] oh);
      logic [2:0] idx = '0;
      for (int i = 0; i < 8; i++) idx = idx | (oh[i] ? 3'(i) : 3'd0);
      return idx;
   endfunction
endpackage

// File: rtl/ddr3_rr_pick.sv
// ddr3_rr_pick: combinational round-robin winner, searching upward from last_grant+1 with wrap.
module ddr3_rr_pick #(
   parameter int NREQ = 2,
   parameter int LGW  = 1
) (
   input  logic [NREQ-1:0] i_req_enable,
   input  logic [LGW-1:0]  i_last_grant,
   output logic [NREQ-1:0] o_win,
   output logic            o_valid
);
   always_comb begin
      o_win = '0;
      // walk from farthest to nearest so the nearest requester overwrites
      for (int i = NREQ; i >= 1; i--) begin
         automatic logic [LGW-1:0] idx = LGW'((int'(i_last_grant) + i) % NREQ);
         if (i_req_enable[idx]) begin
            o_win = '0;
            o_win[idx] = 1'b1;
         end
      end
   end
   assign o_valid = |i_req_enable;
endmodule

// File: rtl/ddr3_rd_arbiter.sv
// ddr3_rd_arbiter: round-robin sharing of the DDR3 read engine among NREQ command machines.
// Define DDR3_RD_TIMEOUT_EN to add a watchdog that aborts a read after TIMEOUT_CYCLES.
module ddr3_rd_arbiter
   import ddr3_pkg::*;
#(
   parameter int NREQ           = 2,
   parameter int TIMEOUT_CYCLES = DDR3_RD_TIMEOUT_DEF
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NREQ-1:0]                   req_enable,
   input  logic [NREQ-1:0][DDR3_ADDR_W-1:0]  req_start_addr,
   input  logic [NREQ-1:0][DDR3_BURST_W-1:0] req_burst_cnt,
   output logic [NREQ-1:0]                   req_grant,
   output logic [NREQ-1:0]                   req_done,
   output logic [NREQ-1:0]                   req_error,
   output logic [DDR3_ADDR_W-1:0]            ddr3_rd_start_addr,
   output logic [DDR3_BURST_W-1:0]           ddr3_rd_burst_cnt,
   output logic                              enable_reading,
   input  logic                              reading_done,
   output logic                              busy
);
   localparam int LGW = $clog2(NREQ);
   if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("ddr3_rd_arbiter: NREQ must be 2..8 and TIMEOUT_CYCLES positive");
   end
   arb_state_t             r_state, w_state_nxt;
   logic [LGW-1:0]         r_last_grant, w_last_nxt, w_idx;
   logic [NREQ-1:0]        w_win, w_grant_nxt, w_done_nxt;
   logic                   w_valid, w_en_nxt, w_wd_hit, r_sync1, reading_done_sync2;
   logic [DDR3_ADDR_W-1:0] w_addr_nxt;
   logic [DDR3_BURST_W-1:0] w_burst_nxt;
   ddr3_rr_pick #(.NREQ(NREQ), .LGW(LGW)) u_pick (
      .i_req_enable(req_enable),
      .i_last_grant(r_last_grant),
      .o_win       (w_win),
      .o_valid     (w_valid)
   );
   assign w_idx = LGW'(oh2idx(8'(w_win)));
   assign busy  = r_state != ST_IDLE;
   always_comb begin
      w_state_nxt = r_state;
      w_last_nxt  = r_last_grant;
      w_grant_nxt = req_grant;
      w_addr_nxt  = ddr3_rd_start_addr;
      w_burst_nxt = ddr3_rd_burst_cnt;
      w_en_nxt    = enable_reading;
      w_done_nxt  = '0;
      case (r_state)
         ST_IDLE: if (w_valid) begin
            w_grant_nxt = w_win;
            w_addr_nxt  = req_start_addr[w_idx];
            w_burst_nxt = req_burst_cnt[w_idx];
            w_last_nxt  = w_idx;
            w_state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            w_en_nxt    = ddr3_rd_burst_cnt != '0;
            w_done_nxt  = w_en_nxt ? '0 : req_grant;
            w_state_nxt = w_en_nxt ? ST_READ : ST_WAIT_CLR;
         end
         ST_READ: if (reading_done_sync2 || w_wd_hit) begin
            w_en_nxt    = 1'b0;
            w_done_nxt  = req_grant;
            w_state_nxt = ST_WAIT_CLR;
         end
         // a done flag still high from the last read must not finish the next one
         ST_WAIT_CLR: if (!reading_done_sync2 && !(|(req_enable & req_grant))) begin
            w_grant_nxt = '0;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state            <= ST_IDLE;
         r_last_grant       <= LGW'(NREQ - 1);
         req_grant          <= '0;
         req_done           <= '0;
         ddr3_rd_start_addr <= '0;
         ddr3_rd_burst_cnt  <= '0;
         enable_reading     <= 1'b0;
         r_sync1            <= 1'b0;
         reading_done_sync2 <= 1'b0;
      end else begin
         r_state            <= w_state_nxt;
         r_last_grant       <= w_last_nxt;
         req_grant          <= w_grant_nxt;
         req_done           <= w_done_nxt;
         ddr3_rd_start_addr <= w_addr_nxt;
         ddr3_rd_burst_cnt  <= w_burst_nxt;
         enable_reading     <= w_en_nxt;
         r_sync1            <= reading_done;
         reading_done_sync2 <= r_sync1;
      end
   end
`ifdef DDR3_RD_TIMEOUT_EN
   localparam int WDW = ($clog2(TIMEOUT_CYCLES + 1) > 21) ? $clog2(TIMEOUT_CYCLES + 1) : 21;
   logic [WDW-1:0] r_wd;
   assign w_wd_hit = (r_state == ST_READ) && (r_wd == WDW'(TIMEOUT_CYCLES - 1));
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wd      <= '0;
         req_error <= '0;
      end else begin
         r_wd      <= (r_state == ST_READ) ? r_wd + 1'b1 : '0;
         req_error <= (w_wd_hit && !reading_done_sync2) ? req_grant : '0;
      end
   end
`else
   assign w_wd_hit  = 1'b0;
   assign req_error = '0;
`endif
endmodule

// File: tb/tb_ddr3_rd_arbiter.sv
// tb_ddr3_rd_arbiter: directed checks of grant order, latencies, stale-done hold-off and reset.
// The watchdog case is exercised when DDR3_RD_TIMEOUT_EN is defined.
module tb_ddr3_rd_arbiter;
   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [1:0]       req_enable = '0;
   logic [1:0][22:0] req_start_addr = '0;
   logic [1:0][23:0] req_burst_cnt = '0;
   logic [1:0]       req_grant, req_done, req_error;
   logic [22:0]      ddr3_rd_start_addr;
   logic [23:0]      ddr3_rd_burst_cnt;
   logic             enable_reading, busy;
   logic             reading_done = 1'b0;
   int               n_chk = 0, n_fail = 0, oh_viol = 0, err_seen = 0;

   ddr3_rd_arbiter #(.NREQ(2), .TIMEOUT_CYCLES(64)) dut (
      .clk               (clk),
      .reset             (reset),
      .req_enable        (req_enable),
      .req_start_addr    (req_start_addr),
      .req_burst_cnt     (req_burst_cnt),
      .req_grant         (req_grant),
      .req_done          (req_done),
      .req_error         (req_error),
      .ddr3_rd_start_addr(ddr3_rd_start_addr),
      .ddr3_rd_burst_cnt (ddr3_rd_burst_cnt),
      .enable_reading    (enable_reading),
      .reading_done      (reading_done),
      .busy              (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if ($countones(req_grant) > 1) oh_viol++;
      if (|req_error) err_seen++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // one full read from the grant edge through release, reader answering 20 cycles after enable
   task automatic run_read(input logic [1:0] g, input logic [22:0] a, input logic [23:0] b,
                           input logic [1:0] pend, input int hold);
      tick();
      check("grant", req_grant, g);
      check("rd_addr", ddr3_rd_start_addr, a);
      check("rd_burst", ddr3_rd_burst_cnt, b);
      check("busy", busy, 1);
      check("en_early", enable_reading, 0);
      req_enable = req_enable | pend;
      tick();
      check("en_on", enable_reading, 1);
      tick(20);
      check("en_hold", enable_reading, 1);
      check("done_early", req_done, 0);
      reading_done = 1'b1;
      tick(2);
      check("done_sync", req_done, 0);
      tick();
      check("done_pulse", req_done, g);
      check("en_off", enable_reading, 0);
      req_enable = req_enable & ~g;
      tick(hold);
      reading_done = 1'b0;
      tick(2);
      check("wait_clr", req_grant, g);
      check("busy_wait", busy, 1);
      check("done_once", req_done, 0);
      tick();
      check("grant_clr", req_grant, 0);
      check("idle", busy, 0);
   endtask

   initial begin
      tick(3);
      check("rst_grant", req_grant, 0);
      check("rst_done", req_done, 0);
      check("rst_err", req_error, 0);
      check("rst_en", enable_reading, 0);
      check("rst_busy", busy, 0);
      check("rst_addr", ddr3_rd_start_addr, 0);
      check("rst_burst", ddr3_rd_burst_cnt, 0);
      reset = 1'b0;
      // single request from requester 0
      req_start_addr[0] = 23'h000100;
      req_burst_cnt[0]  = 24'h10;
      req_enable        = 2'b01;
      run_read(2'b01, 23'h000100, 24'h10, 2'b00, 0);
      // zero burst from requester 1 at the top address
      req_start_addr[1] = 23'h7FFFFF;
      req_burst_cnt[1]  = 24'h0;
      req_enable        = 2'b10;
      tick();
      check("zb_grant", req_grant, 2'b10);
      check("zb_addr", ddr3_rd_start_addr, 23'h7FFFFF);
      check("zb_en1", enable_reading, 0);
      tick();
      check("zb_done", req_done, 2'b10);
      check("zb_en2", enable_reading, 0);
      req_enable = 2'b00;
      tick();
      check("zb_clr", req_grant, 0);
      check("zb_done_off", req_done, 0);
      check("zb_en3", enable_reading, 0);
      // round robin with both requesters pending
      req_start_addr[0] = 23'h012345;
      req_burst_cnt[0]  = 24'hFFFFFF;
      req_start_addr[1] = 23'h054321;
      req_burst_cnt[1]  = 24'h000001;
      req_enable        = 2'b11;
      run_read(2'b01, 23'h012345, 24'hFFFFFF, 2'b00, 0);
      req_enable = req_enable | 2'b01;
      run_read(2'b10, 23'h054321, 24'h000001, 2'b00, 0);
      run_read(2'b01, 23'h012345, 24'hFFFFFF, 2'b00, 0);
      // stale done held 10 cycles while requester 1 waits
      req_enable = 2'b01;
      run_read(2'b01, 23'h012345, 24'hFFFFFF, 2'b10, 10);
      run_read(2'b10, 23'h054321, 24'h000001, 2'b00, 0);
      // reset during a read by requester 0, then requester 0 must win again
      req_enable = 2'b01;
      tick();
      check("mr_grant", req_grant, 2'b01);
      tick();
      check("mr_en", enable_reading, 1);
      req_enable = 2'b11;
      reset = 1'b1;
      tick();
      check("mr_rst_grant", req_grant, 0);
      check("mr_rst_en", enable_reading, 0);
      check("mr_rst_busy", busy, 0);
      check("mr_rst_addr", ddr3_rd_start_addr, 0);
      reset = 1'b0;
      tick();
      check("mr_rewin", req_grant, 2'b01);
      reset = 1'b1;
      req_enable = 2'b00;
      tick(2);
      reset = 1'b0;
`ifdef DDR3_RD_TIMEOUT_EN
      req_start_addr[0] = 23'h000200;
      req_burst_cnt[0]  = 24'h5;
      req_enable        = 2'b01;
      tick();
      check("wd_grant", req_grant, 2'b01);
      tick();
      check("wd_en", enable_reading, 1);
      tick(63);
      check("wd_en_hold", enable_reading, 1);
      check("wd_no_done", req_done, 0);
      check("wd_no_err", req_error, 0);
      tick();
      check("wd_done", req_done, 2'b01);
      check("wd_err", req_error, 2'b01);
      check("wd_en_off", enable_reading, 0);
      req_enable = 2'b00;
      tick();
      check("wd_clr", req_grant, 0);
      check("wd_err_off", req_error, 0);
      check("err_pulses", err_seen, 1);
`else
      check("err_pulses", err_seen, 0);
`endif
      check("grant_onehot", oh_viol, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
